// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_rd_pkg
// Brief  : Shared types and constants for the FIFO read-side stream engine.
// Rev    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int OUT_BUF_DEPTH = 3;
    localparam int BUF_CNT_W     = $clog2(OUT_BUF_DEPTH + 1);
    // Buffered words plus the one possibly in flight must fit without overflow.
    localparam int CREDIT_W      = $clog2(OUT_BUF_DEPTH + 2);

    function automatic logic credit_ok(input logic [BUF_CNT_W-1:0] cnt,
                                       input logic                 inflight);
        logic [CREDIT_W-1:0] w_used;
        w_used = {{(CREDIT_W-BUF_CNT_W){1'b0}}, cnt}
               + {{(CREDIT_W-1){1'b0}}, inflight};
        return (w_used < CREDIT_W'(OUT_BUF_DEPTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module : fifo_stream_reader_if
// Brief  : Valid/ready word stream between the read engine and its consumer.
// Rev    : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module : fifo_rd_skid
// Brief  : Small in-order register buffer with push/pop and head output.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [BUF_CNT_W-1:0]  o_count,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_mem [OUT_BUF_DEPTH];
    logic [BUF_CNT_W-1:0]  r_cnt;

    logic                  w_pop;
    logic                  w_push;
    logic [BUF_CNT_W-1:0]  w_wr_idx;

    assign w_pop    = i_pop && (r_cnt != '0);
    assign w_push   = i_push && ((r_cnt != BUF_CNT_W'(OUT_BUF_DEPTH)) || w_pop);
    // A pop shifts everything down one slot, so the tail slot moves with it.
    assign w_wr_idx = w_pop ? (r_cnt - BUF_CNT_W'(1)) : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
                if (w_push && (w_wr_idx == BUF_CNT_W'(i))) begin
                    r_mem[i] <= i_data;
                end else if (w_pop && (i < OUT_BUF_DEPTH - 1)) begin
                    r_mem[i] <= r_mem[(i + 1) % OUT_BUF_DEPTH];
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + BUF_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - BUF_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_data  = r_mem[0];
    assign o_count = r_cnt;
    assign o_valid = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : fifo_stream_reader
// Brief  : Drains a synchronous FIFO onto a valid/ready stream at full rate.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    fifo_stream_reader_if.master  m_if,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  underflow_err
);

    rd_state_e             r_state;
    logic                  r_inflight;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_words;
    logic                  r_uflow;

    logic                  w_rd_en;
    logic                  w_valid;
    logic                  w_handshake;
    logic [BUF_CNT_W-1:0]  w_buf_cnt;
    logic [DATA_WIDTH-1:0] w_head;

    // Read issue depends only on registered state and the empty flag, never on m_ready.
    assign w_rd_en     = (r_state == RUN) && !fifo_empty && credit_ok(w_buf_cnt, r_inflight);
    assign w_handshake = w_valid && m_if.m_ready;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (fifo_data_out),
        .i_pop   (m_if.m_ready),
        .o_data  (w_head),
        .o_count (w_buf_cnt),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_inflight <= 1'b0;
            r_words    <= '0;
            r_uflow    <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_handshake) begin
                r_words <= r_words + CNT_WIDTH'(1);
            end
            if (fifo_underflow && w_rd_en) begin
                r_uflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        r_state <= RUN;
                    end else if (!r_inflight && (w_buf_cnt == '0)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en     = w_rd_en;
    assign m_if.m_valid   = w_valid;
    assign m_if.m_data    = w_head;
    assign busy           = r_busy;
    assign words_out      = r_words;
    assign underflow_err  = r_uflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_stream_reader
// Brief  : Directed self-checking bench with a behavioural FIFO read port.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd_en;
    logic          busy;
    logic [CW-1:0] words_out;
    logic          underflow_err;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_if           (s_if.master),
        .busy           (busy),
        .words_out      (words_out),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: count-based empty flag, one-cycle read latency.
    logic [DW-1:0] fmem [32];
    int wptr = 0;
    int rptr = 0;
    int rd_cnt = 0;

    always_comb begin
        fifo_empty     = (wptr == rptr);
        fifo_underflow = fifo_rd_en && (wptr == rptr);
    end

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (wptr != rptr) begin
                fifo_data_out <= fmem[rptr % 32];
                rptr          <= rptr + 1;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wptr % 32] = DW'(first + i);
            wptr            = wptr + 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int exp;
        s_if.m_ready = 1'b0;

        // Reset values while reset is held
        #2;
        chk("rst_rd_en",  32'(fifo_rd_en),    32'd0);
        chk("rst_valid",  32'(s_if.m_valid),  32'd0);
        chk("rst_data",   32'(s_if.m_data),   32'd0);
        chk("rst_busy",   32'(busy),          32'd0);
        chk("rst_words",  32'(words_out),     32'd0);
        chk("rst_uflow",  32'(underflow_err), 32'd0);
        step(2);
        rst_n = 1'b1;

        // Full-rate stream
        step(1);
        preload(1, 8);
        s_if.m_ready = 1'b1;
        enable       = 1'b1;
        base         = rd_cnt;
        step(1);
        chk("fr_rd_first", 32'(fifo_rd_en),   32'd1);
        chk("fr_lat_e0",   32'(s_if.m_valid), 32'd0);
        step(1);
        chk("fr_lat_e1",   32'(s_if.m_valid), 32'd0);
        step(1);
        for (int k = 1; k <= 8; k++) begin
            chk("fr_valid", 32'(s_if.m_valid), 32'd1);
            chk("fr_data",  32'(s_if.m_data),  32'(k));
            step(1);
        end
        enable = 1'b0;
        step(4);
        chk("fr_reads", 32'(rd_cnt - base),  32'd8);
        chk("fr_words", 32'(words_out),      32'd8);
        chk("fr_uflow", 32'(underflow_err),  32'd0);
        chk("fr_busy",  32'(busy),           32'd0);
        chk("fr_valid_end", 32'(s_if.m_valid), 32'd0);

        // Asynchronous reset mid-stream
        preload(1, 8);
        s_if.m_ready = 1'b0;
        enable       = 1'b1;
        step(4);
        chk("rm_valid_pre", 32'(s_if.m_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_rd_en", 32'(fifo_rd_en),    32'd0);
        chk("rm_valid", 32'(s_if.m_valid),  32'd0);
        chk("rm_data",  32'(s_if.m_data),   32'd0);
        chk("rm_busy",  32'(busy),          32'd0);
        chk("rm_words", 32'(words_out),     32'd0);
        chk("rm_uflow", 32'(underflow_err), 32'd0);
        enable = 1'b0;
        step(1);
        wptr  = rptr;
        rst_n = 1'b1;
        step(1);
        chk("rm_busy_after",  32'(busy),      32'd0);
        chk("rm_words_after", 32'(words_out), 32'd0);

        // Backpressure
        preload(1, 8);
        s_if.m_ready = 1'b0;
        enable       = 1'b1;
        base         = rd_cnt;
        step(10);
        chk("bp_reads", 32'(rd_cnt - base), 32'd3);
        chk("bp_valid", 32'(s_if.m_valid),  32'd1);
        chk("bp_hold",  32'(s_if.m_data),   32'd1);
        s_if.m_ready = 1'b1;
        exp = 1;
        for (int c = 0; c < 30 && exp <= 8; c++) begin
            if (s_if.m_valid && s_if.m_ready) begin
                chk("bp_data", 32'(s_if.m_data), 32'(exp));
                exp++;
            end
            step(1);
        end
        chk("bp_count", 32'(exp), 32'd9);
        step(3);
        chk("bp_no_dup", 32'(s_if.m_valid), 32'd0);
        enable = 1'b0;
        step(3);
        chk("bp_words",     32'(words_out),    32'd8);
        chk("bp_reads_all", 32'(rd_cnt - base), 32'd8);

        // Empty FIFO
        enable = 1'b1;
        base   = rd_cnt;
        step(20);
        chk("em_reads", 32'(rd_cnt - base),  32'd0);
        chk("em_valid", 32'(s_if.m_valid),   32'd0);
        chk("em_uflow", 32'(underflow_err),  32'd0);
        chk("em_busy",  32'(busy),           32'd1);
        enable = 1'b0;
        step(3);
        chk("em_idle", 32'(busy), 32'd0);

        // Disable in the same cycle as the 4th read
        preload(1, 8);
        s_if.m_ready = 1'b1;
        enable       = 1'b1;
        base         = rd_cnt;
        exp          = 1;
        for (int c = 0; c < 40; c++) begin
            if (enable && fifo_rd_en && (rd_cnt - base == 3)) begin
                enable = 1'b0;
            end
            if (s_if.m_valid && s_if.m_ready) begin
                chk("dis_data", 32'(s_if.m_data), 32'(exp));
                exp++;
                if (exp == 5) break;
            end
            step(1);
        end
        chk("dis_seen4", 32'(exp), 32'd5);
        chk("dis_enable_dropped", 32'(enable), 32'd0);
        step(1);
        chk("dis_busy_hold", 32'(busy),         32'd1);
        chk("dis_empty_buf", 32'(s_if.m_valid), 32'd0);
        chk("dis_no_read",   32'(fifo_rd_en),   32'd0);
        step(1);
        chk("dis_busy_fall", 32'(busy),           32'd0);
        chk("dis_reads",     32'(rd_cnt - base),  32'd4);
        chk("dis_words",     32'(words_out),      32'd12);
        enable = 1'b1;
        for (int c = 0; c < 30 && exp <= 8; c++) begin
            if (s_if.m_valid && s_if.m_ready) begin
                chk("dis_resume", 32'(s_if.m_data), 32'(exp));
                exp++;
            end
            step(1);
        end
        chk("dis_count", 32'(exp), 32'd9);
        enable = 1'b0;
        step(4);
        chk("dis_words_wrap16", 32'(words_out), 32'd0);

        // Counter wrap after 17 handshakes from reset
        rst_n = 1'b0;
        step(1);
        wptr  = rptr;
        rst_n = 1'b1;
        preload(16'h0100, 17);
        s_if.m_ready = 1'b1;
        enable       = 1'b1;
        exp          = 0;
        for (int c = 0; c < 60 && exp < 17; c++) begin
            if (s_if.m_valid && s_if.m_ready) begin
                chk("wr_data", 32'(s_if.m_data), 32'(16'h0100 + exp));
                exp++;
            end
            step(1);
        end
        enable = 1'b0;
        step(4);
        chk("wr_count", 32'(exp),           32'd17);
        chk("wr_words", 32'(words_out),     32'd1);
        chk("wr_uflow", 32'(underflow_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
